// File: rtl/cut_bist_ctrl_if.sv
// Signal bundle between the BIST controller and its test-side peer.
// The peer drives start/golden_sig and returns the CUT response on po.
interface cut_bist_ctrl_if #(
    parameter int PI_W  = 3,
    parameter int PO_W  = 3,
    parameter int SIG_W = 8
);
    logic             start;
    logic [SIG_W-1:0] golden_sig;
    logic [PI_W-1:0]  pi;
    logic [PO_W-1:0]  po;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;

    modport master (
        output start, golden_sig, po,
        input  pi, busy, done, pass, signature
    );

    modport slave (
        input  start, golden_sig, po,
        output pi, busy, done, pass, signature
    );
endinterface

// File: rtl/cut_bist_ctrl.sv
// BIST controller: exhaustive pattern drive, MISR compaction of the CUT
// response and a final compare against a latched golden signature.
module cut_bist_ctrl #(
    parameter int               PI_W    = 3,
    parameter int               PO_W    = 3,
    parameter int               SIG_W   = 8,
    parameter logic [SIG_W-1:0] POLY    = 8'h71,
    parameter int               PAT_CNT = 8
) (
    input logic            clk,
    input logic            rst,
    cut_bist_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(PAT_CNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAT_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CMP,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [PI_W-1:0]  pi_q, pi_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [SIG_W-1:0] sig_q, sig_n;
    logic [SIG_W-1:0] gold_q, gold_n;
    logic             pass_q, pass_n;
    logic [SIG_W-1:0] po_ext;
    logic [SIG_W-1:0] misr_nx;

    always_comb begin
        po_ext = '0;
        po_ext[PO_W-1:0] = bus.po;
    end

    // Shift left, fold the MSB back through the taps, absorb the response.
    assign misr_nx = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (POLY & {SIG_W{sig_q[SIG_W-1]}})
                   ^ po_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pi_q   <= '0;
            cnt_q  <= '0;
            sig_q  <= '0;
            gold_q <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_n;
            pi_q   <= pi_n;
            cnt_q  <= cnt_n;
            sig_q  <= sig_n;
            gold_q <= gold_n;
            pass_q <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        pi_n    = pi_q;
        cnt_n   = cnt_q;
        sig_n   = sig_q;
        gold_n  = gold_q;
        pass_n  = pass_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    gold_n  = bus.golden_sig;
                    sig_n   = '0;
                    cnt_n   = '0;
                    pi_n    = '0;
                    pass_n  = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                sig_n = misr_nx;
                cnt_n = cnt_q + 1'b1;
                // The last pattern stays on pi until the next run.
                if (cnt_q == LAST) begin
                    state_n = CMP;
                end else begin
                    pi_n = pi_q + 1'b1;
                end
            end
            CMP: begin
                pass_n  = (sig_q == gold_q);
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.pi        = pi_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Bench for cut_bist_ctrl: randomized CUT responses checked against a
// polynomial-division MISR model computed over the applied patterns.
module tb_cut_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cut_bist_ctrl_if #(.PI_W(3), .PO_W(3), .SIG_W(8)) bus ();

    cut_bist_ctrl #(
        .PI_W(3), .PO_W(3), .SIG_W(8), .POLY(8'h71), .PAT_CNT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // CUT stand-in: 0 constant, 1 truth table, 2 single-pattern inject
    int         mode = 0;
    logic [2:0] const_po = 3'd0;
    logic [2:0] tt [0:7];

    always_comb begin
        bus.po = const_po;
        if (mode == 1) bus.po = tt[bus.pi];
        else if (mode == 2) bus.po = (bus.busy && bus.pi == 3'd0) ? 3'b100 : 3'b000;
    end

    logic [2:0] pi_tr   [0:15];
    logic [7:0] sig_tr  [0:15];
    logic       busy_tr [0:15];
    logic       done_tr [0:15];
    logic       pass_tr [0:15];
    logic [7:0] exp_sig [0:15];
    logic [7:0] exp_final;

    // MISR as division by x^8+x^6+x^5+x^4+1 plus the injected response.
    function automatic logic [7:0] misr_ref(logic [7:0] s, logic [2:0] p);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h171;
        return t[7:0] ^ {5'd0, p};
    endfunction

    function automatic logic [2:0] po_model(int k);
        if (mode == 1) return tt[k];
        if (mode == 2) return (k == 0) ? 3'b100 : 3'b000;
        return const_po;
    endfunction

    task automatic build_model();
        exp_sig[1] = 8'h00;
        for (int k = 0; k < 8; k++) exp_sig[k+2] = misr_ref(exp_sig[k+1], po_model(k));
        exp_final = exp_sig[9];
    endtask

    task automatic rand_table();
        for (int k = 0; k < 8; k++) tt[k] = 3'($urandom_range(0, 7));
    endtask

    // Start a run and record 13 cycles after the accepting edge.
    task automatic do_run(input logic [7:0] g, input int restart_at);
        @(negedge clk);
        bus.start = 1'b1;
        bus.golden_sig = g;
        @(posedge clk);
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            pi_tr[n]   = bus.pi;
            sig_tr[n]  = bus.signature;
            busy_tr[n] = bus.busy;
            done_tr[n] = bus.done;
            pass_tr[n] = bus.pass;
            bus.start = (n == restart_at);
            bus.golden_sig = 8'($urandom);
        end
    endtask

    function automatic int done_count();
        int c = 0;
        for (int n = 1; n <= 13; n++) if (done_tr[n]) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.golden_sig = 8'h00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            checks++;
            if ({bus.pi, bus.busy, bus.done, bus.pass, bus.signature} !== 14'd0) begin
                failures++;
                $display("FAIL reset_idle[%0d] pi=%0d busy=%b done=%b pass=%b sig=%h want all 0",
                         i, bus.pi, bus.busy, bus.done, bus.pass, bus.signature);
            end
            bus.start = 1'b0;
        end
        bus.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_beats_start busy=%b want 0", bus.busy);
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_const();
        mode = 0;
        const_po = 3'b001;
        build_model();
        do_run(8'hFF, -1);
        for (int n = 1; n <= 9; n++) begin
            checks++;
            if (pi_tr[n] !== 3'((n < 9) ? n - 1 : 7)) begin
                failures++;
                $display("FAIL const_pi[%0d] got=%0d want=%0d", n, pi_tr[n], (n < 9) ? n - 1 : 7);
            end
            checks++;
            if (sig_tr[n] !== exp_sig[n]) begin
                failures++;
                $display("FAIL const_sig[%0d] got=%h want=%h", n, sig_tr[n], exp_sig[n]);
            end
        end
        checks++;
        if (sig_tr[10] !== 8'hFF) begin
            failures++;
            $display("FAIL const_final got=%h want=ff", sig_tr[10]);
        end
        checks++;
        if (done_tr[10] !== 1'b1 || done_count() != 1) begin
            failures++;
            $display("FAIL const_done done10=%b pulses=%0d want 1,1", done_tr[10], done_count());
        end
        checks++;
        if ({busy_tr[1], busy_tr[10], busy_tr[11], pass_tr[10]} !== 4'b1101) begin
            failures++;
            $display("FAIL const_busy_pass got=%b want=1101",
                     {busy_tr[1], busy_tr[10], busy_tr[11], pass_tr[10]});
        end
    endtask

    task automatic test_mismatch();
        mode = 0;
        const_po = 3'b001;
        do_run(8'hFE, -1);
        checks++;
        if ({done_tr[10], pass_tr[10]} !== 2'b10 || sig_tr[10] !== 8'hFF) begin
            failures++;
            $display("FAIL mismatch done=%b pass=%b sig=%h want 1 0 ff",
                     done_tr[10], pass_tr[10], sig_tr[10]);
        end
    endtask

    task automatic test_zero_inject();
        logic [7:0] g;
        mode = 0;
        const_po = 3'b000;
        g = 8'($urandom_range(1, 255));
        do_run(g, -1);
        for (int n = 1; n <= 10; n++) begin
            checks++;
            if (sig_tr[n] !== 8'h00) begin
                failures++;
                $display("FAIL zero_sig[%0d] got=%h want=00", n, sig_tr[n]);
            end
        end
        mode = 2;
        build_model();
        do_run(exp_final, -1);
        checks++;
        if (sig_tr[10] !== exp_final || pass_tr[10] !== 1'b1) begin
            failures++;
            $display("FAIL inject_sig got=%h pass=%b want=%h pass=1", sig_tr[10], pass_tr[10], exp_final);
        end
        checks++;
        if (sig_tr[10] === 8'h00) begin
            failures++;
            $display("FAIL inject_nonzero got=%h want nonzero", sig_tr[10]);
        end
    endtask

    task automatic test_busy_protect();
        int waited;
        mode = 1;
        rand_table();
        build_model();
        do_run(exp_final, 4);
        for (int n = 5; n <= 8; n++) begin
            checks++;
            if (pi_tr[n] !== 3'(n - 1) || busy_tr[n] !== 1'b1) begin
                failures++;
                $display("FAIL busy_pi[%0d] got=%0d busy=%b want=%0d busy=1", n, pi_tr[n], busy_tr[n], n - 1);
            end
        end
        checks++;
        if (done_tr[10] !== 1'b1 || done_count() != 1 || sig_tr[10] !== exp_final || pass_tr[10] !== 1'b1) begin
            failures++;
            $display("FAIL busy_done done10=%b pulses=%0d sig=%h pass=%b want 1 1 %h 1",
                     done_tr[10], done_count(), sig_tr[10], pass_tr[10], exp_final);
        end
        do_run(exp_final, 10);
        checks++;
        if ({busy_tr[11], busy_tr[12], busy_tr[13]} !== 3'b000) begin
            failures++;
            $display("FAIL start_in_done busy11..13=%b want 000", {busy_tr[11], busy_tr[12], busy_tr[13]});
        end
        do_run(exp_final, 11);
        checks++;
        if ({pass_tr[11], busy_tr[12], pass_tr[12]} !== 3'b110 || pi_tr[12] !== 3'd0 || sig_tr[12] !== 8'h00) begin
            failures++;
            $display("FAIL restart pass11=%b busy12=%b pass12=%b pi12=%0d sig12=%h want 1 1 0 0 00",
                     pass_tr[11], busy_tr[12], pass_tr[12], pi_tr[12], sig_tr[12]);
        end
        waited = 0;
        while (!bus.done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done got=%b want=1 within 20 cycles", bus.done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int pulses;
        mode = 1;
        rand_table();
        @(negedge clk);
        bus.start = 1'b1;
        bus.golden_sig = 8'($urandom);
        @(posedge clk);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.pi !== 3'd4) begin
            failures++;
            $display("FAIL midrun_pi got=%0d want=4", bus.pi);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.pi, bus.busy, bus.done, bus.pass, bus.signature} !== 14'd0) begin
            failures++;
            $display("FAIL midrun_reset pi=%0d busy=%b done=%b pass=%b sig=%h want all 0",
                     bus.pi, bus.busy, bus.done, bus.pass, bus.signature);
        end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midrun_no_done got=%0d pulses want=0", pulses);
        end
        build_model();
        do_run(exp_final, -1);
        checks++;
        if (done_tr[10] !== 1'b1 || sig_tr[10] !== exp_final || pass_tr[10] !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_run done=%b sig=%h pass=%b want 1 %h 1",
                     done_tr[10], sig_tr[10], pass_tr[10], exp_final);
        end
    endtask

    task automatic test_cut_random();
        logic [7:0] g;
        mode = 1;
        for (int k = 0; k < 8; k++) begin
            tt[k][0] = k[0] ^ k[1];
            tt[k][1] = k[1] & k[2];
            tt[k][2] = ~(k[0] | k[2]);
        end
        for (int r = 0; r < 5; r++) begin
            if (r > 0) rand_table();
            build_model();
            g = (r == 0 || $urandom_range(0, 1) == 1) ? exp_final : 8'($urandom);
            do_run(g, -1);
            checks++;
            if (sig_tr[10] !== exp_final || pass_tr[10] !== (g == exp_final) || done_tr[10] !== 1'b1) begin
                failures++;
                $display("FAIL cut_run[%0d] sig=%h pass=%b done=%b want %h %b 1",
                         r, sig_tr[10], pass_tr[10], done_tr[10], exp_final, (g == exp_final));
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.golden_sig = 8'h00;
        test_reset();
        test_const();
        test_mismatch();
        test_zero_inject();
        test_busy_protect();
        test_reset_midrun();
        test_cut_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
